// File: rtl/m_issue_scoreboard_pkg.sv
// rtl/m_issue_scoreboard_pkg.sv - shared kinds, widths and operand-use helpers for the issue scoreboard
package m_issue_scoreboard_pkg;

    localparam int REG_SEL_W   = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_RRR  = 2'd1,
        KIND_RRI  = 2'd2,
        KIND_RR   = 2'd3
    } e_kind;

    function automatic logic kind_uses_rs(e_kind k);
        return k != KIND_NONE;
    endfunction

    // RRI carries an immediate where rq would sit, so rq is not a real source
    function automatic logic kind_uses_rq(e_kind k);
        return (k == KIND_RRR) || (k == KIND_RR);
    endfunction

    function automatic logic kind_writes_rd(e_kind k);
        return (k == KIND_RRR) || (k == KIND_RRI);
    endfunction

endpackage

// File: rtl/m_sat_counter.sv
// rtl/m_sat_counter.sv - up/down counter that stops at SAT and never underflows
module m_sat_counter #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SAT   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !dec && count != SAT) begin
            count <= count + WIDTH'(1);
        end else if (dec && !inc && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/m_issue_scoreboard.sv
// rtl/m_issue_scoreboard.sv - RAW/WAW scoreboard with one registered issue slot
// Optional retire-bypass of hazard and inflight checks: SCOREBOARD_BYPASS_EN
module m_issue_scoreboard
    import m_issue_scoreboard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int SEL_W        = REG_SEL_W,
    parameter int MAX_INFLIGHT = 4,
    parameter int ZERO_REG     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  e_kind                  dec_kind,
    input  logic [SEL_W-1:0]       rs_sel,
    input  logic [SEL_W-1:0]       rq_sel,
    input  logic [SEL_W-1:0]       rd,
    output logic                   iss_valid,
    input  logic                   iss_ready,
    output logic [SEL_W-1:0]       iss_rd,
    output e_kind                  iss_kind,
    input  logic                   wb_valid,
    input  logic [SEL_W-1:0]       wb_rd,
    output logic                   wb_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int INF_W = $clog2(NUM_REGS + 2);

    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_eff;
    logic [INF_W-1:0]    inflight;
    logic                use_rs, use_rq, write_rd, marks_rd;
    logic                hazard, retire, credit, inflight_ok, accept;

    assign retire = wb_valid & pend[wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
    logic [NUM_REGS-1:0] wb_onehot;

    always_comb begin
        wb_onehot        = '0;
        wb_onehot[wb_rd] = wb_valid;
    end

    assign pend_eff = pend & ~wb_onehot;
    assign credit   = retire;
`else
    assign pend_eff = pend;
    assign credit   = 1'b0;
`endif

    always_comb begin
        use_rs      = kind_uses_rs(dec_kind);
        use_rq      = kind_uses_rq(dec_kind);
        write_rd    = kind_writes_rd(dec_kind);
        marks_rd    = write_rd & !((ZERO_REG != 0) && (rd == '0));
        hazard      = (use_rs & pend_eff[rs_sel]) | (use_rq & pend_eff[rq_sel])
                    | (write_rd & pend_eff[rd]);
        inflight_ok = inflight < (INF_W'(MAX_INFLIGHT) + INF_W'(credit));
        dec_ready   = !rst & !flush & !hazard & (!iss_valid | iss_ready)
                    & (!write_rd | inflight_ok);
        accept      = dec_valid & dec_ready;
    end

    // A register set by accept and cleared by retire in the same cycle stays pending
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pend <= '0;
        end else begin
            if (retire) begin
                pend[wb_rd] <= 1'b0;
            end
            if (accept && marks_rd) begin
                pend[rd] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_rd    <= '0;
            iss_kind  <= KIND_NONE;
            wb_err    <= 1'b0;
        end else begin
            wb_err <= wb_valid & !pend[wb_rd];
            if (flush) begin
                iss_valid <= 1'b0;
            end else if (accept) begin
                iss_valid <= 1'b1;
                iss_rd    <= rd;
                iss_kind  <= dec_kind;
            end else if (iss_ready) begin
                iss_valid <= 1'b0;
            end
        end
    end

    m_sat_counter #(
        .WIDTH (INF_W),
        .SAT   (INF_W'(MAX_INFLIGHT))
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .inc   (accept & marks_rd),
        .dec   (retire),
        .count (inflight)
    );

    m_sat_counter #(
        .WIDTH (STALL_CNT_W),
        .SAT   ({STALL_CNT_W{1'b1}})
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (dec_valid & !dec_ready),
        .dec   (1'b0),
        .count (stall_cnt)
    );

endmodule
